bomb_slot_scheduler: RTL
========================

Name: bomb_slot_scheduler

Overview:
- Owns a fixed pool of bomb fuse slots and shares it between the two players' bomb-put requests.
- Per-cycle operation: arbitrates simultaneous puts, enforces per-player capacity, counts fuses down and triggers chain detonations.
- Serialises detonations, one per handshake, to the downstream flame/explode generator.
- Sits between controller (p1/p2_put, coordinates), Gadget (cap, len) and the explode/Wall/Gameover path; runs on the game clock (clk_30).

Parameters:
NUM_SLOTS, 8, number of shared bomb slots (2..16)
FUSE_TICKS, 90, cycles from grant to fuse expiry (3 s at 30 Hz)
COR_W, 8, tile coordinate width ({y[3:0],x[3:0]}, 16x16 grid)

Ports:
clk  in  1  game clock
reset  in  1  synchronous, active-high reset
run  in  1  game running; low freezes fuses and rejects puts
p1_put, p2_put  in  1  single-cycle put request pulses
p1_cor, p2_cor  in  COR_W  requesting player's tile
p1_len, p2_len  in  2  flame length latched into the slot at grant
p1_cap, p2_cap  in  3  max simultaneous bombs per player
chain_in  in  256  cells currently under flame
det_ready  in  1  flame generator accepts a detonation
p1_grant, p2_grant  out  1  one-cycle pulse: put accepted
p1_active, p2_active  out  3  bombs currently owned
bomb_map  out  256  occupancy, bit index = cor
det_valid  out  1  detonation offered
det_cor  out  COR_W  detonating cell
det_len  out  2  detonating flame length
det_owner  out  1  0 = P1, 1 = P2

Behaviour:
- Reset (synchronous, any time incl. mid-fuse): all slots FREE; all outputs 0; rr_pri = P1. Pending puts and detonations are discarded.
- Slot FSM: FREE -> ARMED on grant (fuse = FUSE_TICKS-1; cor/len/owner latched). ARMED -> FIRE when fuse == 0 and run = 1, or when chain_in[cor] = 1 (chain ignores run). FIRE -> FREE on det_valid & det_ready for that slot.
- Fuse decrements by 1 per cycle only while run = 1 and the slot is ARMED. It never wraps.
- Put acceptance is decided on registered state in the request cycle t. Grant pulse, bomb_map bit and active++ all appear at t+1.
- A put is rejected silently (no grant, no state change) if any of these holds:
  - run = 0;
  - bomb_map[cor] = 1;
  - px_active >= px_cap;
  - no FREE slot.
- Requests are never queued.
- Both puts in the same cycle:
  - Different cells and two FREE slots: both granted.
  - Same cell, or only one FREE slot: the rr_pri player is considered first; the other is rejected. rr_pri toggles after every contested cycle.
- Slot allocation: lowest-index FREE slot to the first-served player, next lowest to the second.
- Detonation select: lowest-index slot in FIRE.
  - det_valid/cor/len/owner are registered and held stable until accepted.
  - After acceptance, the next FIRE slot (if any) is offered on the following cycle. Throughput is 1 detonation per cycle.
- Acceptance clears bomb_map[cor] and decrements owner active at t+1. A put to that cell in the accept cycle is still rejected (occupied at t).
- Same player increment and decrement in one cycle: active unchanged.
- Chain: chain_in hitting any number of ARMED slots moves all of them to FIRE together; they drain in index order.
- Cap lowered below active: no effect on live bombs; only new puts are blocked.

Decomposition:
- Package bomb_pkg:
  - slot_state_e {FREE, ARMED, FIRE};
  - owner_e {P1, P2};
  - slot_t struct {state, fuse[6:0], cor, len, owner};
  - GRID_CELLS = 256, COR_W.
- Sub-module bomb_slot: one slot FSM plus fuse counter, with alloc/latch inputs, chain/run/ack inputs and state/cor outputs. Instantiated NUM_SLOTS times.
- Top level holds arbitration, rr_pri, priority encoders, counters and the bomb_map OR-reduction.

Test Plan:
- P1 put cor 0x12, cap 3, run 1 -> p1_grant at t+1, bomb_map[0x12] = 1, p1_active = 1; det_valid at t+1+FUSE_TICKS with cor 0x12, owner 0.
- P1 and P2 put cor 0x33 same cycle, rr_pri = P1 -> only p1_grant. Repeat on 0x34 -> only p2_grant (rr toggled).
- P2 cap 2 with 2 bombs live, put 0x40 -> no grant, p2_active stays 2; after one detonation accepted, a put is granted.
- Slots at 0x10 (fuse 80) and 0x11 (fuse 85), chain_in[0x10] & chain_in[0x11] for one cycle -> both FIRE; det_ready held low 3 cycles, det_cor stable 0x10; then 0x10 and 0x11 on consecutive accepted cycles.
- run = 0 for 20 cycles mid-fuse -> expiry delayed exactly 20 cycles; puts during the freeze rejected.
- 8 slots full plus a 9th put -> rejected. reset asserted mid-fuse -> next cycle bomb_map = 0, det_valid = 0, active = 0.

Source files
------------

// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared types and constants for the bomb slot scheduler
package bomb_pkg;

  localparam int GRID_CELLS = 256;
  localparam int COR_W      = 8;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } slot_state_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } owner_e;

  typedef struct packed {
    slot_state_e      state;
    logic [6:0]       fuse;
    logic [COR_W-1:0] cor;
    logic [1:0]       len;
    owner_e           owner;
  } slot_t;

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: FREE/ARMED/FIRE state and its fuse counter
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = 90
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  alloc,
  input  logic [COR_W-1:0]      alloc_cor,
  input  logic [1:0]            alloc_len,
  input  logic                  alloc_owner,
  input  logic [GRID_CELLS-1:0] chain_in,
  input  logic                  ack,
  output slot_state_e           state,
  output logic [COR_W-1:0]      cor,
  output logic [1:0]            len,
  output logic                  owner,
  output logic                  will_fire
);

  slot_t slot;
  logic  fire_cond;

  // Chain hits ignore run; fuse expiry only counts while the game runs.
  always_comb begin
    fire_cond = (slot.state == ARMED) &&
                (chain_in[slot.cor] || (run && slot.fuse == 7'd0));
    will_fire = fire_cond || (slot.state == FIRE && !ack);
  end

  assign state = slot.state;
  assign cor   = slot.cor;
  assign len   = slot.len;
  assign owner = slot.owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
    end else begin
      case (slot.state)
        FREE: begin
          if (alloc) begin
            slot.state <= ARMED;
            slot.fuse  <= 7'(FUSE_TICKS - 1);
            slot.cor   <= alloc_cor;
            slot.len   <= alloc_len;
            slot.owner <= owner_e'(alloc_owner);
          end
        end
        ARMED: begin
          if (fire_cond) slot.state <= FIRE;
          else if (run)  slot.fuse  <= slot.fuse - 7'd1;
        end
        FIRE: begin
          if (ack) slot.state <= FREE;
        end
        default: slot.state <= FREE;
      endcase
    end
  end

endmodule

// File: rtl/bomb_slot_scheduler.sv
// rtl/bomb_slot_scheduler.sv - shares bomb slots between two players and serialises detonations
module bomb_slot_scheduler
  import bomb_pkg::slot_state_e, bomb_pkg::FREE, bomb_pkg::owner_e,
         bomb_pkg::P1, bomb_pkg::P2, bomb_pkg::GRID_CELLS;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int FUSE_TICKS = 90,
  parameter int COR_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  p1_put,
  input  logic                  p2_put,
  input  logic [COR_W-1:0]      p1_cor,
  input  logic [COR_W-1:0]      p2_cor,
  input  logic [1:0]            p1_len,
  input  logic [1:0]            p2_len,
  input  logic [2:0]            p1_cap,
  input  logic [2:0]            p2_cap,
  input  logic [GRID_CELLS-1:0] chain_in,
  input  logic                  det_ready,
  output logic                  p1_grant,
  output logic                  p2_grant,
  output logic [2:0]            p1_active,
  output logic [2:0]            p2_active,
  output logic [GRID_CELLS-1:0] bomb_map,
  output logic                  det_valid,
  output logic [COR_W-1:0]      det_cor,
  output logic [1:0]            det_len,
  output logic                  det_owner
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  slot_state_e          slot_state [NUM_SLOTS];
  logic [COR_W-1:0]     slot_cor   [NUM_SLOTS];
  logic [1:0]           slot_len   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_owner, will_fire, alloc, alloc_p2, ack;

  owner_e               rr_pri;
  logic [IDX_W-1:0]     det_slot, first_idx, second_idx, fire_idx, p1_slot, p2_slot;
  logic                 any_free, two_free, any_fire;
  logic                 p1_ok, p2_ok, contested, g1, g2, p1_dec, p2_dec;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .alloc      (alloc[g]),
      .alloc_cor  (alloc_p2[g] ? p2_cor : p1_cor),
      .alloc_len  (alloc_p2[g] ? p2_len : p1_len),
      .alloc_owner(alloc_p2[g]),
      .chain_in   (chain_in),
      .ack        (ack[g]),
      .state      (slot_state[g]),
      .cor        (slot_cor[g]),
      .len        (slot_len[g]),
      .owner      (slot_owner[g]),
      .will_fire  (will_fire[g])
    );
  end

  // Descending scans leave the lowest index in first_idx; the previous one slides to second_idx.
  always_comb begin
    any_free   = 1'b0;
    two_free   = 1'b0;
    first_idx  = '0;
    second_idx = '0;
    any_fire   = 1'b0;
    fire_idx   = '0;
    bomb_map   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      ack[i] = det_valid && det_ready && (det_slot == IDX_W'(i));
      if (slot_state[i] == FREE) begin
        two_free   = any_free;
        any_free   = 1'b1;
        second_idx = first_idx;
        first_idx  = IDX_W'(i);
      end else begin
        bomb_map[slot_cor[i]] = 1'b1;
      end
      if (will_fire[i]) begin
        any_fire = 1'b1;
        fire_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    p1_ok     = run && p1_put && !bomb_map[p1_cor] && (p1_active < p1_cap) && any_free;
    p2_ok     = run && p2_put && !bomb_map[p2_cor] && (p2_active < p2_cap) && any_free;
    contested = p1_ok && p2_ok && ((p1_cor == p2_cor) || !two_free);
    g1        = p1_ok && !(contested && rr_pri == P2);
    g2        = p2_ok && !(contested && rr_pri == P1);
    p1_slot   = (g2 && rr_pri == P2) ? second_idx : first_idx;
    p2_slot   = (g1 && rr_pri == P1) ? second_idx : first_idx;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      alloc_p2[i] = g2 && (p2_slot == IDX_W'(i));
      alloc[i]    = (g1 && (p1_slot == IDX_W'(i))) || alloc_p2[i];
    end
    p1_dec = det_valid && det_ready && (det_owner == P1);
    p2_dec = det_valid && det_ready && (det_owner == P2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_pri    <= P1;
      p1_grant  <= 1'b0;
      p2_grant  <= 1'b0;
      p1_active <= '0;
      p2_active <= '0;
      det_valid <= 1'b0;
      det_slot  <= '0;
      det_cor   <= '0;
      det_len   <= '0;
      det_owner <= 1'b0;
    end else begin
      p1_grant  <= g1;
      p2_grant  <= g2;
      if (contested) rr_pri <= (rr_pri == P1) ? P2 : P1;
      p1_active <= p1_active + {2'b00, g1} - {2'b00, p1_dec};
      p2_active <= p2_active + {2'b00, g2} - {2'b00, p2_dec};
      // The offer register only reloads once the current detonation is taken.
      if (!det_valid || det_ready) begin
        det_valid <= any_fire;
        det_slot  <= fire_idx;
        det_cor   <= any_fire ? slot_cor[fire_idx]   : '0;
        det_len   <= any_fire ? slot_len[fire_idx]   : '0;
        det_owner <= any_fire ? slot_owner[fire_idx] : 1'b0;
      end
    end
  end

endmodule
